mem_burst_responder: RTL and testbench
======================================

// Module: mem_burst_responder
// PURPOSE
//  Memory-side responder for cache block fills. Accepts one block-read request
//  from the fill controller, waits a fixed access latency, then returns the
//  8 words of the 16-byte block, one per cycle, with a valid strobe.
//  Also services single-word writes. Sits between the cache fill controller
//  and the word-organised backing memory array, which is held inside this block.
// PARAMETERS
//  LATENCY   4   cycles from accepted request to first data beat (legal 1..15)
//  ADDR_W    16  byte-address width
//  DATA_W    16  word width
//  MEM_WORDS 2**(ADDR_W-1)  backing array depth in words
// PORTS
//  clk         in   1       clock, rising edge
//  rst_n       in   1       asynchronous active-low reset
//  req         in   1       block-read request, sampled only in IDLE
//  wr          in   1       single-word write, sampled only in IDLE
//  addr        in   ADDR_W  byte address (bit 0 ignored)
//  data_in     in   DATA_W  write data
//  busy        out  1       high from the cycle after a read is accepted until the last beat
//  data_valid  out  1       high on each of the 8 returned beats
//  data_out    out  DATA_W  read data; 0 when data_valid is low
//  beat_num    out  3       index of the current beat (0..7)
//  burst_done  out  1       one-cycle pulse with beat 7
// BEHAVIOUR
//  Reset (async, rst_n low): state = IDLE. busy, data_valid, burst_done = 0;
//   data_out = 0; beat_num = 0; latency counter = 0. Array contents not reset.
//  States:
//   IDLE  -> WAIT when req=1. Latch base = {addr[15:4],4'h0}; load cnt = LATENCY-1.
//   WAIT  counts cnt down to 0; at cnt==0 -> BURST with beat = 0.
//   BURST presents word at base+2*beat; beat increments each cycle.
//         beat==7 -> IDLE.
//  Timing: request accepted at edge T.
//   Beat k is valid in cycle T+LATENCY+k (k = 0..7).
//   A new req is accepted at the edge that ends beat 7 at the earliest (back-to-back bursts).
//   All outputs are registered; data_out, beat_num, data_valid, burst_done change together.
//  Reads: the array is read synchronously one cycle ahead of the beat.
//   No combinational path exists from addr to data_out.
//  Writes: wr=1 in IDLE writes data_in to word addr[15:1] at that edge. No response.
//   busy stays 0.
//  Simultaneous wr and req in IDLE:
//   - the write commits and the read is accepted at the same edge;
//   - the burst returns the post-write data.
//  req or wr while busy/WAIT/BURST: ignored. No queueing; the latched base is unchanged.
//  Address bits [3:0] of a req are ignored. The block never crosses a 16-byte
//   boundary. Base 0xFFF0 returns 0xFFF0..0xFFFE with no wrap past 0xFFFF.
//  LATENCY=1: first beat in cycle T+1. WAIT is bypassed (IDLE -> BURST directly).
//  rst_n asserted mid-WAIT or mid-BURST: the burst is abandoned immediately and
//   outputs go to their reset values. No further beats are produced after rst_n rises.
// TESTING
//  1. Preload word 0x1000+2k = 0xA000+k; req, addr=0x1006, LATENCY=4
//     -> beats 0..7 in cycles T+4..T+11 with data 0xA000..0xA007; burst_done with beat 7.
//  2. wr addr=0x2002 data=0xBEEF, then req addr=0x2000
//     -> beat 1 = 0xBEEF; busy never rises for the write.
//  3. wr and req in the same cycle, addr=0x3004, data=0x1234 -> beat 2 = 0x1234.
//  4. req during WAIT with addr=0x4000
//     -> ignored: original block returned, exactly 8 beats, no second burst.
//  5. rst_n low during beat 3
//     -> data_valid, busy, data_out = 0 immediately; no beats after release; next req works normally.
//  6. req addr=0xFFFF
//     -> beats from 0xFFF0..0xFFFE. Back-to-back req at beat 7 -> second burst starts LATENCY cycles later.

Source files
------------

// File: rtl/mem_burst_responder_if.sv
// Request/response bundle between the cache fill controller (master) and the
// memory burst responder (slave).
interface mem_burst_responder_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              req;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_in;
  logic              busy;
  logic              data_valid;
  logic [DATA_W-1:0] data_out;
  logic [2:0]        beat_num;
  logic              burst_done;

  modport slave (
    input  req, wr, addr, data_in,
    output busy, data_valid, data_out, beat_num, burst_done
  );

  modport master (
    output req, wr, addr, data_in,
    input  busy, data_valid, data_out, beat_num, burst_done
  );
endinterface

// File: rtl/mem_burst_responder.sv
// Memory-side responder for cache block fills: returns the eight words of a
// 16-byte block after a fixed latency, and services single-word writes.
module mem_burst_responder #(
  parameter int LATENCY   = 4,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int MEM_WORDS = 2**(ADDR_W-1)
) (
  input logic                  clk,
  input logic                  rst_n,
  mem_burst_responder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT, BURST} state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [2:0]          beatPtr_q, beatPtr_d;
  logic [ADDR_W-5:0]   blk_q, blk_d;
  logic                busy_q, busy_d;
  logic                valid_q;
  logic [DATA_W-1:0]   dataOut_q;
  logic [2:0]          beatNum_q;
  logic                done_q;

  logic                emit;
  logic [2:0]          emitBeat;
  logic [ADDR_W-2:0]   rdIdx;

  logic [DATA_W-1:0]   mem [MEM_WORDS];

  logic                unusedAddrLsb;
  assign unusedAddrLsb = bus.addr[0];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    beatPtr_d = beatPtr_q;
    blk_d     = blk_q;
    busy_d    = 1'b0;
    emit      = 1'b0;
    emitBeat  = beatPtr_q;
    case (state_q)
      IDLE: begin
        if (bus.req) begin
          blk_d     = bus.addr[ADDR_W-1:4];
          busy_d    = 1'b1;
          beatPtr_d = 3'd0;
          if (LATENCY == 1) begin
            state_d = BURST;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        busy_d = 1'b1;
        // The edge that sees cnt==0 already registers beat 0.
        if (cnt_q == 4'd0) begin
          emit      = 1'b1;
          emitBeat  = 3'd0;
          beatPtr_d = 3'd1;
          state_d   = BURST;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      BURST: begin
        busy_d    = 1'b1;
        emit      = 1'b1;
        emitBeat  = beatPtr_q;
        beatPtr_d = beatPtr_q + 3'd1;
        if (beatPtr_q == 3'd7) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rdIdx = {blk_q, emitBeat};

  always_ff @(posedge clk) begin
    if (rst_n && (state_q == IDLE) && bus.wr) begin
      mem[bus.addr[ADDR_W-1:1]] <= bus.data_in;
    end
  end

  // Beat data is read straight into the output register, so a write accepted
  // with the request is always visible to the burst that follows it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      beatPtr_q <= 3'd0;
      blk_q     <= '0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      dataOut_q <= '0;
      beatNum_q <= 3'd0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      beatPtr_q <= beatPtr_d;
      blk_q     <= blk_d;
      busy_q    <= busy_d;
      valid_q   <= emit;
      dataOut_q <= emit ? mem[rdIdx] : '0;
      beatNum_q <= emit ? emitBeat : 3'd0;
      done_q    <= emit && (emitBeat == 3'd7);
    end
  end

  assign bus.busy       = busy_q;
  assign bus.data_valid = valid_q;
  assign bus.data_out   = dataOut_q;
  assign bus.beat_num   = beatNum_q;
  assign bus.burst_done = done_q;

endmodule

// File: tb/tb_mem_burst_responder.sv
// Directed plus randomized bench for mem_burst_responder, checked against a
// word-array model of the backing memory and the burst timing rules.
module tb_mem_burst_responder;

  localparam int LAT = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  mem_burst_responder_if #(.ADDR_W(16), .DATA_W(16)) busIf ();

  mem_burst_responder #(.LATENCY(LAT), .ADDR_W(16), .DATA_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busIf)
  );

  int checks   = 0;
  int failures = 0;

  logic [15:0] modelMem [int];
  logic [15:0] expWords [8];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One IDLE-cycle transaction; the model commits a write before capturing the block.
  task automatic applyStimulus(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
    int baseWord;
    busIf.req     = r;
    busIf.wr      = w;
    busIf.addr    = a;
    busIf.data_in = d;
    tick;
    busIf.req = 1'b0;
    busIf.wr  = 1'b0;
    if (w) modelMem[int'(a) / 2] = d;
    if (r) begin
      baseWord = (int'(a) / 16) * 8;
      for (int k = 0; k < 8; k++) expWords[k] = modelMem[baseWord + k];
    end
  endtask

  task automatic preloadBlock(input logic [15:0] base, input bit useRandom, input logic [15:0] pattern);
    for (int k = 0; k < 8; k++)
      applyStimulus(1'b0, 1'b1, base + 16'(2 * k), useRandom ? 16'($urandom) : pattern + 16'(k));
  endtask

  task automatic collectBurst(input string tag, input int lastN, input int injectAt,
                              input logic injReq, input logic injWr,
                              input logic [15:0] injAddr, input logic [15:0] injData);
    int k;
    bit inBurst;
    for (int n = 1; n <= lastN; n++) begin
      tick;
      busIf.req = 1'b0;
      busIf.wr  = 1'b0;
      k = n - LAT;
      inBurst = (k >= 0) && (k <= 7);
      checkOutput({tag, ".valid"}, 32'(busIf.data_valid), 32'(inBurst));
      checkOutput({tag, ".data"},  32'(busIf.data_out),   inBurst ? 32'(expWords[k]) : 32'd0);
      checkOutput({tag, ".beat"},  32'(busIf.beat_num),   inBurst ? 32'(k) : 32'd0);
      checkOutput({tag, ".done"},  32'(busIf.burst_done), 32'(k == 7));
      checkOutput({tag, ".busy"},  32'(busIf.busy),       32'd1);
      if (n == injectAt) begin
        busIf.req     = injReq;
        busIf.wr      = injWr;
        busIf.addr    = injAddr;
        busIf.data_in = injData;
      end
    end
  endtask

  task automatic checkIdle(input string tag, input int cycles);
    for (int n = 0; n < cycles; n++) begin
      tick;
      checkOutput({tag, ".valid"}, 32'(busIf.data_valid), 32'd0);
      checkOutput({tag, ".busy"},  32'(busIf.busy),       32'd0);
      checkOutput({tag, ".data"},  32'(busIf.data_out),   32'd0);
      checkOutput({tag, ".done"},  32'(busIf.burst_done), 32'd0);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".valid"}, 32'(busIf.data_valid), 32'd0);
    checkOutput({tag, ".busy"},  32'(busIf.busy),       32'd0);
    checkOutput({tag, ".data"},  32'(busIf.data_out),   32'd0);
    checkOutput({tag, ".beat"},  32'(busIf.beat_num),   32'd0);
    checkOutput({tag, ".done"},  32'(busIf.burst_done), 32'd0);
  endtask

  initial begin
    logic [15:0] bases [3];
    logic [15:0] a;
    logic        w;

    busIf.req     = 1'b0;
    busIf.wr      = 1'b0;
    busIf.addr    = '0;
    busIf.data_in = '0;

    #1 rst_n = 1'b0;
    #2 checkAllZero("reset");
    #20;
    @(negedge clk) rst_n = 1'b1;
    tick;

    $display("[TB] block read with offset request address");
    preloadBlock(16'h1000, 1'b0, 16'hA000);
    applyStimulus(1'b1, 1'b0, 16'h1006, 16'h0);
    collectBurst("t1", LAT + 7, 0, 1'b0, 1'b0, 16'h0, 16'h0);
    checkIdle("t1.idle", 2);

    $display("[TB] write then read back");
    preloadBlock(16'h2000, 1'b1, 16'h0);
    applyStimulus(1'b0, 1'b1, 16'h2002, 16'hBEEF);
    checkOutput("t2.wrBusy", 32'(busIf.busy), 32'd0);
    checkIdle("t2.wrIdle", 1);
    applyStimulus(1'b1, 1'b0, 16'h2000, 16'h0);
    collectBurst("t2", LAT + 7, 0, 1'b0, 1'b0, 16'h0, 16'h0);
    checkIdle("t2.idle", 1);

    $display("[TB] simultaneous write and read");
    preloadBlock(16'h3000, 1'b1, 16'h0);
    applyStimulus(1'b1, 1'b1, 16'h3004, 16'h1234);
    collectBurst("t3", LAT + 7, 0, 1'b0, 1'b0, 16'h0, 16'h0);
    checkIdle("t3.idle", 1);

    $display("[TB] request during WAIT is ignored");
    applyStimulus(1'b1, 1'b0, 16'h1000, 16'h0);
    collectBurst("t4", LAT + 7, 2, 1'b1, 1'b0, 16'h4000, 16'h0);
    checkIdle("t4.idle", LAT + 9);

    $display("[TB] write during BURST is ignored");
    applyStimulus(1'b1, 1'b0, 16'h2000, 16'h0);
    collectBurst("t4w", LAT + 7, LAT + 2, 1'b0, 1'b1, 16'h1002, 16'hDEAD);
    checkIdle("t4w.idle", 1);
    applyStimulus(1'b1, 1'b0, 16'h1000, 16'h0);
    collectBurst("t4r", LAT + 7, 0, 1'b0, 1'b0, 16'h0, 16'h0);
    checkIdle("t4r.idle", 1);

    $display("[TB] reset during beat 3");
    applyStimulus(1'b1, 1'b0, 16'h3000, 16'h0);
    collectBurst("t5", LAT + 3, 0, 1'b0, 1'b0, 16'h0, 16'h0);
    #2 rst_n = 1'b0;
    #1 checkAllZero("t5.rst");
    tick;
    checkAllZero("t5.held");
    @(negedge clk) rst_n = 1'b1;
    checkIdle("t5.post", LAT + 9);
    applyStimulus(1'b1, 1'b0, 16'h3006, 16'h0);
    collectBurst("t5n", LAT + 7, 0, 1'b0, 1'b0, 16'h0, 16'h0);
    checkIdle("t5n.idle", 1);

    $display("[TB] top block and back-to-back bursts");
    preloadBlock(16'hFFF0, 1'b1, 16'h0);
    applyStimulus(1'b1, 1'b0, 16'hFFFF, 16'h0);
    collectBurst("t6a", LAT + 7, 0, 1'b0, 1'b0, 16'h0, 16'h0);
    applyStimulus(1'b1, 1'b0, 16'h2004, 16'h0);
    checkOutput("t6.gapValid", 32'(busIf.data_valid), 32'd0);
    checkOutput("t6.gapBusy",  32'(busIf.busy),       32'd1);
    collectBurst("t6b", LAT + 7, 0, 1'b0, 1'b0, 16'h0, 16'h0);
    checkIdle("t6b.idle", 1);

    $display("[TB] randomized reads with optional same-cycle writes");
    bases[0] = 16'h5000;
    bases[1] = 16'h5010;
    bases[2] = 16'h7FF0;
    for (int b = 0; b < 3; b++) preloadBlock(bases[b], 1'b1, 16'h0);
    for (int i = 0; i < 6; i++) begin
      a = bases[$urandom_range(0, 2)] + 16'($urandom_range(0, 15));
      w = 1'($urandom_range(0, 1));
      applyStimulus(1'b1, w, a, 16'($urandom));
      collectBurst("rnd", LAT + 7, 0, 1'b0, 1'b0, 16'h0, 16'h0);
      if ($urandom_range(0, 1) == 1) checkIdle("rnd.idle", 1);
    end
    checkIdle("end.idle", 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
